axi_lite_arbiter_n: RTL and testbench

- N-master to 1-slave AXI-lite arbiter; generalises the fixed two-master (IFU/LSU) arbiter in the core top.
- Masters (IFU, LSU, later DMA/debug) share one memory/peripheral slave port.
- Adds configurable master count, configurable data/strobe/address widths and a selectable fixed-priority or round-robin policy.
- Exactly one transaction (read or write) is outstanding at the slave at a time.

---
 rtl/axi_lite_arbiter_n_if.sv | 48 ++++
 rtl/axi_lite_arbiter_n.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_arbiter_n.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_n_if.sv
// AXI-lite channel bundle for the N-master arbiter.
// One instance with NUM_M masters carries the upstream side. Per-master
// signals are flat vectors, and slice i belongs to master i. rdata, rresp
// and bresp are broadcast to every master. An instance with NUM_M=1 is
// the single downstream slave port.
interface axi_lite_arbiter_n_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 8
);
  // read address / read data
  logic [NUM_M*ADDR_W-1:0] araddr;
  logic [NUM_M-1:0]        arvalid;
  logic [NUM_M-1:0]        arready;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              rresp;
  logic [NUM_M-1:0]        rvalid;
  logic [NUM_M-1:0]        rready;

  // write address / write data / write response
  logic [NUM_M*ADDR_W-1:0] awaddr;
  logic [NUM_M-1:0]        awvalid;
  logic [NUM_M-1:0]        awready;
  logic [NUM_M*DATA_W-1:0] wdata;
  logic [NUM_M*STRB_W-1:0] wstrb;
  logic [NUM_M-1:0]        wvalid;
  logic [NUM_M-1:0]        wready;
  logic [1:0]              bresp;
  logic [NUM_M-1:0]        bvalid;
  logic [NUM_M-1:0]        bready;

  // The side that issues transactions.
  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  // The side that services transactions.
  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter_n.sv
// N-master to 1-slave AXI-lite arbiter.
// Only one transaction (read or write) is outstanding at the slave at any
// time. Arbitration takes one IDLE cycle and chooses either the lowest
// requesting index or, in round-robin mode, the first requester at or
// after the pointer. The registered grant_id steers all slave-side
// traffic. Masters that do not hold the grant see ready=0 and valid=0 on
// every channel.
module axi_lite_arbiter_n #(
  parameter  int NUM_M   = 2,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int STRB_W  = 8,
  parameter  int RR_MODE = 0,
  localparam int ID_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  axi_lite_arbiter_n_if.slave  m,
  axi_lite_arbiter_n_if.master s,
  output logic                grant_valid,
  output logic [ID_W-1:0]     grant_id
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

  state_t                       state;
  logic                         aw_done;
  logic                         w_done;
  logic [ID_W-1:0]              rr_ptr;
  logic [ID_W-1:0]              next_ptr;
  logic [ID_W-1:0]              win_id;
  logic                         win_vld;
  logic [NUM_M-1:0]             req;
  int                           cand;

  logic [NUM_M-1:0][ADDR_W-1:0] araddr_v;
  logic [NUM_M-1:0][ADDR_W-1:0] awaddr_v;
  logic [NUM_M-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_M-1:0][STRB_W-1:0] wstrb_v;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // View each flat per-master bus as a packed array indexed by master.
  assign araddr_v = m.araddr;
  assign awaddr_v = m.awaddr;
  assign wdata_v  = m.wdata;
  assign wstrb_v  = m.wstrb;

  // A master requests if it has either address channel pending.
  assign req = m.arvalid | m.awvalid;

  // Pointer value used after release: the index after the owner, wrapping.
  assign next_ptr = (grant_id == ID_W'(NUM_M - 1)) ? '0 : grant_id + 1'b1;

  // Pick the winner. The scan starts at 0 (fixed mode) or at rr_ptr
  // (round-robin) and wraps modulo NUM_M. The first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(cand);
      end
    end
  end

  // Slave-side handshakes. The valids are already gated by state and done flags.
  assign ar_hs = s.arvalid[0] & s.arready[0];
  assign r_hs  = s.rvalid[0]  & s.rready[0];
  assign aw_hs = s.awvalid[0] & s.awready[0];
  assign w_hs  = s.wvalid[0]  & s.wready[0];
  assign b_hs  = s.bvalid[0]  & s.bready[0];

  // Transaction FSM: grant ownership, channel sequencing and the RR pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            // If one master has both a read and a write pending, the read goes first.
            state       <= m.arvalid[win_id] ? RD_A : WR_AW;
          end
        end
        RD_A: begin
          if (ar_hs) state <= RD_D;
        end
        RD_D: begin
          if (r_hs) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        WR_AW: begin
          // AW and W may complete in any order, or in the same cycle.
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_B;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_B: begin
          if (b_hs) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake routing between the owner and the slave. Every other master is held at zero.
  always_comb begin
    m.arready = '0;
    m.rvalid  = '0;
    m.awready = '0;
    m.wready  = '0;
    m.bvalid  = '0;
    s.arvalid = '0;
    s.rready  = '0;
    s.awvalid = '0;
    s.wvalid  = '0;
    s.bready  = '0;
    case (state)
      RD_A: begin
        s.arvalid[0]        = m.arvalid[grant_id];
        m.arready[grant_id] = s.arready[0];
      end
      RD_D: begin
        m.rvalid[grant_id]  = s.rvalid[0];
        s.rready[0]         = m.rready[grant_id];
      end
      WR_AW: begin
        s.awvalid[0]        = m.awvalid[grant_id] & ~aw_done;
        s.wvalid[0]         = m.wvalid[grant_id]  & ~w_done;
        m.awready[grant_id] = s.awready[0] & ~aw_done;
        m.wready[grant_id]  = s.wready[0]  & ~w_done;
      end
      WR_B: begin
        m.bvalid[grant_id]  = s.bvalid[0];
        s.bready[0]         = m.bready[grant_id];
      end
      default: ;
    endcase
  end

  // Address and data payloads follow the grant. Responses go to every master.
  assign s.araddr = araddr_v[grant_id];
  assign s.awaddr = awaddr_v[grant_id];
  assign s.wdata  = wdata_v[grant_id];
  assign s.wstrb  = wstrb_v[grant_id];
  assign m.rdata  = s.rdata;
  assign m.rresp  = s.rresp;
  assign m.bresp  = s.bresp;

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// Directed bench for axi_lite_arbiter_n.
// dut_a: two masters, fixed priority, slave with a 2-cycle read latency
// and programmable AW/W ready delays.
// dut_b: three masters, round-robin, slave that answers reads at once.
module tb_axi_lite_arbiter_n;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_arbiter_n_if #(.NUM_M(2), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) ma();
  axi_lite_arbiter_n_if #(.NUM_M(1), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) sa();
  axi_lite_arbiter_n_if #(.NUM_M(3), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) mb();
  axi_lite_arbiter_n_if #(.NUM_M(1), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) sb();

  logic       gva, gvb;
  logic [0:0] gida;
  logic [1:0] gidb;

  axi_lite_arbiter_n #(.NUM_M(2), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .RR_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .m(ma), .s(sa), .grant_valid(gva), .grant_id(gida));

  axi_lite_arbiter_n #(.NUM_M(3), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .RR_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .m(mb), .s(sb), .grant_valid(gvb), .grant_id(gidb));

  int errors = 0;
  int checks = 0;

  // ---------------- slave model A ----------------
  int rd_lat = 2;
  int aw_dly = 0;
  int w_dly  = 0;
  logic rd_busy, aw_got, w_got;
  int rd_cnt, aw_cnt, w_cnt, aw_hs_n, w_hs_n, cyc_n, aw_cyc, w_cyc;
  logic [AW-1:0] cap_awaddr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_wstrb;
  logic [1:0] hs_ar_q, hs_aw_q, hs_w_q;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h8000_0004) ? 32'h0010_0073 : (a ^ 32'h5a5a_5a5a);
  endfunction

  assign sa.arready = ~rd_busy;
  assign sa.awready = (aw_cnt >= aw_dly);
  assign sa.wready  = (w_cnt >= w_dly);
  assign sa.rresp   = 2'b00;
  assign sa.bresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      rd_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; aw_hs_n <= 0; w_hs_n <= 0;
      cyc_n <= 0; aw_cyc <= 0; w_cyc <= 0;
      cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
      hs_ar_q <= '0; hs_aw_q <= '0; hs_w_q <= '0;
      sa.rvalid <= '0; sa.bvalid <= '0; sa.rdata <= '0;
    end else begin
      cyc_n   <= cyc_n + 1;
      hs_ar_q <= ma.arvalid & ma.arready;
      hs_aw_q <= ma.awvalid & ma.awready;
      hs_w_q  <= ma.wvalid & ma.wready;
      if (sa.arvalid[0] && sa.arready[0]) begin
        rd_busy  <= 1'b1;
        rd_cnt   <= 0;
        sa.rdata <= mem_rd(sa.araddr);
      end else if (rd_busy && !sa.rvalid[0]) begin
        if (rd_cnt == rd_lat - 1) sa.rvalid <= 1'b1;
        else rd_cnt <= rd_cnt + 1;
      end
      if (sa.rvalid[0] && sa.rready[0]) begin
        sa.rvalid <= 1'b0;
        rd_busy   <= 1'b0;
      end
      if (sa.awvalid[0] && sa.awready[0]) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_hs_n <= aw_hs_n + 1; aw_cyc <= cyc_n;
        cap_awaddr <= sa.awaddr;
      end else if (sa.awvalid[0]) aw_cnt <= aw_cnt + 1;
      if (sa.wvalid[0] && sa.wready[0]) begin
        w_cnt <= 0; w_got <= 1'b1; w_hs_n <= w_hs_n + 1; w_cyc <= cyc_n;
        cap_wdata <= sa.wdata; cap_wstrb <= sa.wstrb;
      end else if (sa.wvalid[0]) w_cnt <= w_cnt + 1;
      if (aw_got && w_got && !sa.bvalid[0]) begin
        sa.bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (sa.bvalid[0] && sa.bready[0]) sa.bvalid <= 1'b0;
    end
  end

  // ---------------- slave model B (reads only, immediate) ----------------
  assign sb.arready = 1'b1;
  assign sb.awready = 1'b0;
  assign sb.wready  = 1'b0;
  assign sb.bvalid  = 1'b0;
  assign sb.rresp   = 2'b00;
  assign sb.bresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.rvalid <= '0; sb.rdata <= '0;
    end else if (sb.arvalid[0]) begin
      sb.rvalid <= 1'b1; sb.rdata <= sb.araddr;
    end else if (sb.rvalid[0] && sb.rready[0]) sb.rvalid <= 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge. Drop each master valid that completed
  // its handshake on the rising edge just before.
  task automatic cyc();
    @(negedge clk);
    ma.arvalid = ma.arvalid & ~hs_ar_q;
    ma.awvalid = ma.awvalid & ~hs_aw_q;
    ma.wvalid  = ma.wvalid  & ~hs_w_q;
  endtask

  logic [1:0] rv_acc, bv_acc, br_acc;

  // Run until every queued transaction on dut_a has finished.
  task automatic drain(input string name);
    int n;
    n = 0; rv_acc = '0; bv_acc = '0; br_acc = '0;
    while ((ma.arvalid != 0 || ma.awvalid != 0 || ma.wvalid != 0 || gva) && n < 200) begin
      cyc();
      n++;
      rv_acc = rv_acc | ma.rvalid;
      bv_acc = bv_acc | ma.bvalid;
      if (ma.bvalid != 0) br_acc = br_acc | ma.bresp;
    end
    chk({name, " drain"}, 64'(n < 200), 64'd1);
  endtask

  task automatic set_default_payload();
    ma.araddr = {32'h1000_0100, 32'h1000_0000};
    ma.awaddr = {32'h2000_0100, 32'h2000_0000};
    ma.wdata  = {32'h0000_00d1, 32'h0000_00d0};
    ma.wstrb  = {8'h0f, 8'h0f};
  endtask

  typedef struct {
    logic [1:0] arv;
    logic [1:0] awv;
    logic [0:0] gid;
    logic       rd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n, k, lat, aw0, w0;
    logic [1:0] got[6];
    logic prev;

    // Fixed mode: the lowest index wins, and a master's read beats its own write.
    tbl[0] = '{2'b01, 2'b00, 1'b0, 1'b1};
    tbl[1] = '{2'b10, 2'b00, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 2'b00, 1'b0, 1'b1};
    tbl[3] = '{2'b00, 2'b10, 1'b1, 1'b0};
    tbl[4] = '{2'b00, 2'b11, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 2'b01, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 2'b01, 1'b0, 1'b1};
    tbl[7] = '{2'b10, 2'b11, 1'b0, 1'b0};

    set_default_payload();
    ma.rready = 2'b11; ma.bready = 2'b11;
    ma.arvalid = 2'b11; ma.awvalid = 2'b11; ma.wvalid = 2'b11;
    mb.araddr = {32'h300, 32'h200, 32'h100};
    mb.awaddr = '0; mb.wdata = '0; mb.wstrb = '0;
    mb.arvalid = '0; mb.awvalid = '0; mb.wvalid = '0;
    mb.rready = 3'b111; mb.bready = 3'b111;

    // Reset state: requests are present, but every handshake output must stay quiet.
    #12;
    chk("rst grant", {gva, gida, gvb, gidb}, 64'd0);
    chk("rst m outs", {ma.arready, ma.rvalid, ma.awready, ma.wready, ma.bvalid}, 64'd0);
    chk("rst s outs", {sa.arvalid, sa.rready, sa.awvalid, sa.wvalid, sa.bready}, 64'd0);
    ma.arvalid = '0; ma.awvalid = '0; ma.wvalid = '0;
    @(negedge clk); rst = 1'b0;

    // Test 1: M1 reads 0x80000004 from a slave with 2-cycle read latency.
    cyc();
    ma.araddr[32 +: 32] = 32'h8000_0004;
    ma.arvalid = 2'b10;
    lat = 0;
    do begin cyc(); lat++; end while (ma.rvalid == 0 && lat < 20);
    chk("t1 latency", lat, 4);
    chk("t1 rvalid", ma.rvalid, 2'b10);
    chk("t1 rdata", ma.rdata, 32'h0010_0073);
    chk("t1 grant", {gva, gida}, 2'b11);
    cyc();
    chk("t1 release", gva, 1'b0);
    drain("t1");
    set_default_payload();

    // Table: single arbitration decisions from IDLE.
    for (int i = 0; i < 8; i++) begin
      ma.arvalid = tbl[i].arv;
      ma.awvalid = tbl[i].awv;
      ma.wvalid  = tbl[i].awv;
      cyc();
      chk($sformatf("v%0d gid", i), {gva, gida}, {1'b1, tbl[i].gid});
      chk($sformatf("v%0d kind", i), {sa.arvalid, sa.awvalid}, tbl[i].rd ? 2'b10 : 2'b01);
      chk($sformatf("v%0d ready", i), tbl[i].rd ? ma.arready : ma.awready,
          2'b01 << tbl[i].gid);
      drain($sformatf("v%0d", i));
    end

    // Test 2: concurrent reads. M0 goes first, M1 stays gated, then one IDLE cycle passes.
    ma.arvalid = 2'b11;
    cyc();
    chk("t2 first gid", {gva, gida}, 2'b10);
    bad = 0; n = 0;
    while (gva && n < 50) begin
      if (ma.arready[1] || ma.rvalid[1]) bad = 1;
      cyc(); n++;
    end
    chk("t2 m1 gated", bad, 0);
    chk("t2 idle gap", gva, 1'b0);
    cyc();
    chk("t2 second grant", {gva, gida}, 2'b11);
    drain("t2");

    // Test 5: one master raises a read and a write together. The read completes first.
    ma.arvalid = 2'b01; ma.awvalid = 2'b01; ma.wvalid = 2'b01;
    aw0 = aw_hs_n;
    cyc();
    chk("t5 read first", {gva, gida, sa.arvalid, sa.awvalid}, 4'b1010);
    n = 0;
    while (gva && n < 50) begin cyc(); n++; end
    cyc();
    chk("t5 write next", {gva, gida, sa.arvalid, sa.awvalid}, 4'b1001);
    drain("t5");
    chk("t5 aw count", aw_hs_n - aw0, 1);

    // Test 4: M1 write where W completes 2 cycles before AW.
    aw_dly = 2; w_dly = 0;
    aw0 = aw_hs_n; w0 = w_hs_n;
    ma.awaddr[32 +: 32] = 32'ha000_03f8;
    ma.wdata[32 +: 32]  = 32'h0000_0041;
    ma.wstrb[8 +: 8]    = 8'h01;
    ma.awvalid = 2'b10; ma.wvalid = 2'b10;
    drain("t4");
    chk("t4 aw count", aw_hs_n - aw0, 1);
    chk("t4 w count", w_hs_n - w0, 1);
    chk("t4 w before aw", aw_cyc - w_cyc, 2);
    chk("t4 awaddr", cap_awaddr, 32'ha000_03f8);
    chk("t4 wdata/strb", {cap_wdata, cap_wstrb}, {32'h0000_0041, 8'h01});
    chk("t4 bvalid/bresp", {bv_acc, br_acc}, 4'b1000);
    aw_dly = 0;
    set_default_payload();

    // Test 6: reset pulsed in RD_D drops every output at once. Arbitration then resumes.
    ma.arvalid = 2'b01;
    cyc(); cyc();
    chk("t6 in rd_d", {gva, sa.rready}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst grant", {gva, gida}, 2'b00);
    chk("t6 rst outs", {ma.arready, ma.rvalid, ma.awready, ma.wready, ma.bvalid,
                        sa.arvalid, sa.rready, sa.awvalid, sa.wvalid, sa.bready}, 64'd0);
    ma.arvalid = '0;
    @(negedge clk); rst = 1'b0;
    ma.araddr[32 +: 32] = 32'h8000_0004;
    ma.arvalid = 2'b10;
    cyc();
    chk("t6 rearb", {gva, gida, sa.arvalid}, 3'b111);
    drain("t6");
    chk("t6 rvalid seen", rv_acc, 2'b10);

    // Test 3: round-robin over three masters that request reads continuously.
    mb.arvalid = 3'b111;
    k = 0; n = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) got[i] = 2'b11;
    while (k < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (gvb && !prev) begin got[k] = gidb; k++; end
      prev = gvb;
    end
    chk("t3 grants seen", k, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3 grant %0d", i), got[i], 64'(i % 3));
    mb.arvalid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
